// File: rtl/sp_ram_arb_pkg.sv
// Shared types and constants for the single-port RAM arbiter/scrubber.
package sp_ram_arb_pkg;

  // Top-level FSM: zero-fill the RAM, then arbitrate between requesters.
  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int NUM_PORTS = 2;

  // Number of 32-bit words the scrubber has to clear.
  function automatic int scrub_words(input int ram_size);
    return ram_size / 4;
  endfunction

endpackage

// File: rtl/sp_ram_arbiter_if.sv
// Bus bundles for the arbiter: the two-port requester side and the RAM side.
//
// Handshake: a requester raises req_i[p] with addr/we/be/wdata and holds them
// stable until gnt_o[p] is seen high in the same cycle. The access is
// performed in the grant cycle; rvalid_o[p] (with rdata_o[p] for reads)
// follows exactly one cycle after every grant, for reads and writes alike.
import sp_ram_arb_pkg::*;

interface sp_ram_req_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_PORTS-1:0]                   req_i;
  logic [NUM_PORTS-1:0]                   gnt_o;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]   addr_i;
  logic [NUM_PORTS-1:0]                   we_i;
  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0] be_i;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   wdata_i;
  logic [NUM_PORTS-1:0]                   rvalid_o;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   rdata_o;

  // Requesters drive the request fields and observe grant/response.
  modport master (
    output req_i, addr_i, we_i, be_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o
  );

  // The arbiter consumes requests and produces grant/response.
  modport slave (
    input  req_i, addr_i, we_i, be_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o
  );
endinterface

interface sp_ram_mem_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32
);
  logic                    ram_en_o;
  logic [ADDR_WIDTH-1:0]   ram_addr_o;
  logic                    ram_we_o;
  logic [DATA_WIDTH/8-1:0] ram_be_o;
  logic [DATA_WIDTH-1:0]   ram_wdata_o;
  logic [DATA_WIDTH-1:0]   ram_rdata_i;

  // Arbiter side drives the RAM access port.
  modport master (
    output ram_en_o, ram_addr_o, ram_we_o, ram_be_o, ram_wdata_o,
    input  ram_rdata_i
  );

  // RAM side (macro or model) answers with 1-cycle read latency.
  modport slave (
    input  ram_en_o, ram_addr_o, ram_we_o, ram_be_o, ram_wdata_o,
    output ram_rdata_i
  );
endinterface

// File: rtl/sp_ram_arbiter_rr.sv
// Two-input round-robin arbiter. last_q remembers the most recently granted
// port; on a tie the other port wins. Reset value 1 lets port 0 win first.
import sp_ram_arb_pkg::*;

module rr_arbiter_2 (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NUM_PORTS-1:0] req,
  output logic [NUM_PORTS-1:0] gnt
);

  logic last_q;

  // Combinational grant: single requester wins outright, tie goes to !last_q.
  always_comb begin
    gnt = '0;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_q ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Pointer advances to the granted port on every grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (|gnt) begin
      last_q <= gnt[1];
    end
  end

endmodule

// File: rtl/sp_ram_arbiter.sv
// Scrubber + round-robin arbiter in front of a single-port data RAM.
// After reset the RAM is zero-filled one word per cycle (INIT); afterwards
// the access port is shared between the core (port 0) and debug (port 1).
import sp_ram_arb_pkg::*;

module sp_ram_arbiter #(
  parameter int RAM_SIZE   = 32768,
  parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter int DATA_WIDTH = 32,
  parameter int INIT_EN    = 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic          init_done_o,
  output state_e        state_o,
  sp_ram_req_if.slave   req_bus,
  sp_ram_mem_if.master  ram_bus
);

  localparam int WORDS = scrub_words(RAM_SIZE);
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS - 1);

  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]           state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 run;
  logic                 arb_en;
  logic [1:0]           gnt;
  logic [1:0]           rvalid_q;
  logic [ADDR_WIDTH-1:0] scrub_addr;

  assign run        = (state_q == S_RUN);
  // Grants are also killed combinationally by rst so they drop immediately.
  assign arb_en     = run & ~rst;
  assign scrub_addr = ADDR_WIDTH'(cnt_q) << 2;

  assign init_done_o = run;
  assign state_o     = state_e'(state_q);

  // FSM and scrub counter: one zero write per cycle, then RUN forever.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= (INIT_EN != 0) ? S_INIT : S_RUN;
      cnt_q   <= '0;
    end else if (state_q == S_INIT) begin
      if (cnt_q == LAST_CNT) begin
        state_q <= S_RUN;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  rr_arbiter_2 u_arb (
    .clk (clk),
    .rst (rst),
    .en  (arb_en),
    .req (req_bus.req_i),
    .gnt (gnt)
  );

  assign req_bus.gnt_o = gnt;

  // Response strobe: one cycle after each grant, matching RAM read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q <= '0;
    end else begin
      rvalid_q <= gnt;
    end
  end

  assign req_bus.rvalid_o   = rvalid_q;
  assign req_bus.rdata_o[0] = ram_bus.ram_rdata_i;
  assign req_bus.rdata_o[1] = ram_bus.ram_rdata_i;

  // RAM port mux: scrub writes in INIT, granted port in RUN, idle otherwise.
  always_comb begin
    ram_bus.ram_en_o    = 1'b0;
    ram_bus.ram_we_o    = 1'b0;
    ram_bus.ram_addr_o  = req_bus.addr_i[0];
    ram_bus.ram_be_o    = req_bus.be_i[0];
    ram_bus.ram_wdata_o = req_bus.wdata_i[0];
    if (!rst) begin
      if (!run) begin
        ram_bus.ram_en_o    = 1'b1;
        ram_bus.ram_we_o    = 1'b1;
        ram_bus.ram_addr_o  = scrub_addr;
        ram_bus.ram_be_o    = '1;
        ram_bus.ram_wdata_o = '0;
      end else if (gnt[1]) begin
        ram_bus.ram_en_o    = 1'b1;
        ram_bus.ram_we_o    = req_bus.we_i[1];
        ram_bus.ram_addr_o  = req_bus.addr_i[1];
        ram_bus.ram_be_o    = req_bus.be_i[1];
        ram_bus.ram_wdata_o = req_bus.wdata_i[1];
      end else if (gnt[0]) begin
        ram_bus.ram_en_o    = 1'b1;
        ram_bus.ram_we_o    = req_bus.we_i[0];
      end
    end
  end

endmodule
